quicksort_loader: RTL and testbench

- Upstream feeder for the `quicksort` core. Accepts a valid/ready element stream and packs elements into the core's `array_in` word.
- Drives `enable`, `lo_ind` and `hi_ind` to the core, waits for `array_valid`, then captures `sorted_array`.
- Presents the sorted frame downstream with a valid/ready handshake. Performs the enable/valid turnaround the core expects between frames.

---
 rtl/qs_pkg.sv | 25 ++
 rtl/quicksort_loader_if.sv | 38 +++
 rtl/qs_frame_packer.sv | 41 ++++
 rtl/quicksort_loader.sv | 150 +++++++++++++++
 tb/tb_quicksort_loader.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qs_pkg.sv
// qs_pkg: shared types and constants for the quicksort loader.
// Latency: none (declarations only).
// Backpressure: n/a.
package qs_pkg;

  // Loader frame sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SORT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam int DEF_ELEM_W   = 4;
  localparam int DEF_IDX_W    = 4;
  // Idle cycles the sorter needs after array_valid falls before a new frame.
  localparam int DRAIN_CYCLES = 2;

  // Lowest bit of element slot k; element 0 sits at the MSB end.
  function automatic int slot_lsb(input int k, input int arr_width, input int elem_w);
    return (arr_width - 1 - k) * elem_w;
  endfunction

endpackage

// File: rtl/quicksort_loader_if.sv
// quicksort_loader_if: element stream in, sorter handshake, result stream out.
// Latency: none (wiring only).
// Backpressure: in_ready / res_ready valid-ready pairs.
interface quicksort_loader_if
  import qs_pkg::*;
#(
  parameter int ARR_WIDTH = 4,
  parameter int ELEM_W    = DEF_ELEM_W,
  parameter int IDX_W     = DEF_IDX_W
);
  logic [ELEM_W-1:0]           in_data;
  logic                        in_valid;
  logic                        in_last;
  logic                        in_ready;
  logic [ARR_WIDTH*ELEM_W-1:0] array_in;
  logic                        enable;
  logic [IDX_W-1:0]            lo_ind;
  logic [IDX_W-1:0]            hi_ind;
  logic                        array_valid;
  logic [ARR_WIDTH*ELEM_W-1:0] sorted_array;
  logic [ARR_WIDTH*ELEM_W-1:0] res_array;
  logic [IDX_W:0]              res_count;
  logic                        res_valid;
  logic                        res_ready;
  logic                        sort_err;

  // Loader side.
  modport slave (
    input  in_data, in_valid, in_last, array_valid, sorted_array, res_ready,
    output in_ready, array_in, enable, lo_ind, hi_ind, res_array, res_count, res_valid, sort_err
  );

  // Environment side: upstream feeder, sorter core and downstream consumer.
  modport master (
    output in_data, in_valid, in_last, array_valid, sorted_array, res_ready,
    input  in_ready, array_in, enable, lo_ind, hi_ind, res_array, res_count, res_valid, sort_err
  );
endinterface

// File: rtl/qs_frame_packer.sv
// qs_frame_packer: counts accepted beats, drops each element into its slot, flags frame close.
// Latency: slot and count update on the clock after the beat; closed is combinational on the beat.
// Backpressure: none of its own; the caller only asserts beat when it is ready.
module qs_frame_packer
  import qs_pkg::*;
#(
  parameter int ARR_WIDTH = 4,
  parameter int ELEM_W    = DEF_ELEM_W,
  parameter int CNT_W     = DEF_IDX_W + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        beat,
  input  logic [ELEM_W-1:0]           data,
  input  logic                        last,
  output logic [CNT_W-1:0]            count,
  output logic                        closed,
  output logic [ARR_WIDTH*ELEM_W-1:0] word
);

  // Explicit last and the implicit full-frame beat collapse into one close.
  assign closed = beat && (last || (count == CNT_W'(ARR_WIDTH - 1)));

  // Slot insertion; unfilled slots stay all-ones so they sort to the end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      word  <= '1;
    end else if (clear) begin
      count <= '0;
      word  <= '1;
    end else if (beat) begin
      for (int k = 0; k < ARR_WIDTH; k++) begin
        if (count == CNT_W'(k)) word[slot_lsb(k, ARR_WIDTH, ELEM_W) +: ELEM_W] <= data;
      end
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/quicksort_loader.sv
// quicksort_loader: packs a stream into a frame, runs the sorter, presents the sorted frame.
// Latency: closing beat -> enable 1 cycle; array_valid -> res_valid 1 cycle; single element -> res_valid 2 cycles.
// Backpressure: in_ready low from close until drain completes; res_valid held until res_ready.
// Optional: QS_LOADER_TIMEOUT_EN adds a SORT watchdog that returns the unsorted frame with sort_err.
module quicksort_loader
  import qs_pkg::*;
#(
  parameter int ARR_WIDTH      = 4,
  parameter int ELEM_W         = DEF_ELEM_W,
  parameter int IDX_W          = DEF_IDX_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                clock,
  input logic                reset,
  quicksort_loader_if.slave  bus
);

  localparam int CNT_W = IDX_W + 1;
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  state_t                      state, state_n;
  logic                        in_ready_q, enable_q, bypass, armed;
  logic [IDX_W-1:0]            hi_q;
  logic [CNT_W-1:0]            res_count_q, count;
  logic [ARR_WIDTH*ELEM_W-1:0] res_array_q, word;
  logic [DRN_W-1:0]            drain_cnt;
  logic                        beat, closed, clear, capture, copy_in;

`ifdef QS_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout, err_q;
`endif

  assign beat = bus.in_valid && in_ready_q;

  qs_frame_packer #(
    .ARR_WIDTH (ARR_WIDTH),
    .ELEM_W    (ELEM_W),
    .CNT_W     (CNT_W)
  ) u_packer (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .beat   (beat),
    .data   (bus.in_data),
    .last   (bus.in_last),
    .count  (count),
    .closed (closed),
    .word   (word)
  );

  // Next-state and per-cycle strobes of the frame sequencer.
  always_comb begin
    state_n = state;
    clear   = 1'b0;
    capture = 1'b0;
    copy_in = 1'b0;
`ifdef QS_LOADER_TIMEOUT_EN
    timeout = 1'b0;
`endif
    case (state)
      IDLE, LOAD: state_n = closed ? SORT : LOAD;
      SORT: begin
        if (bypass) begin
          // One element is already sorted; the sorter is never asked.
          copy_in = 1'b1;
          state_n = DONE;
        end else if (armed && bus.array_valid) begin
          capture = 1'b1;
          state_n = DONE;
        end
`ifdef QS_LOADER_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          copy_in = 1'b1;
          state_n = DONE;
        end
`endif
      end
      DONE:  if (bus.res_ready) state_n = DRAIN;
      DRAIN: begin
        if (!bus.array_valid && (drain_cnt == DRN_W'(DRAIN_CYCLES))) begin
          clear   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, registered handshake outputs and result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      enable_q    <= 1'b0;
      bypass      <= 1'b0;
      armed       <= 1'b0;
      hi_q        <= '0;
      res_count_q <= '0;
      res_array_q <= '0;
      drain_cnt   <= '0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n == IDLE) || (state_n == LOAD);
      // On the closing beat the bypass register is not yet updated, so decide from count.
      enable_q   <= (state_n == SORT) && !(closed ? (count == '0) : bypass);
      // A result is only trusted once enable has been seen high at a previous edge.
      armed      <= (state == SORT) && (state_n == SORT);
      if (closed) begin
        hi_q        <= count[IDX_W-1:0];
        res_count_q <= count + 1'b1;
        bypass      <= (count == '0);
      end
      if (capture)      res_array_q <= bus.sorted_array;
      else if (copy_in) res_array_q <= word;
      if ((state != DRAIN) || bus.array_valid) drain_cnt <= '0;
      else if (drain_cnt != DRN_W'(DRAIN_CYCLES)) drain_cnt <= drain_cnt + 1'b1;
    end
  end

`ifdef QS_LOADER_TIMEOUT_EN
  // Watchdog on the sorter; error flag lives until its frame is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state == SORT) && enable_q) tmo_cnt <= tmo_cnt + 1'b1;
      else                             tmo_cnt <= '0;
      if (timeout)                                 err_q <= 1'b1;
      else if ((state == DONE) && bus.res_ready)   err_q <= 1'b0;
    end
  end
  assign bus.sort_err = err_q;
`else
  assign bus.sort_err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.array_in  = word;
  assign bus.enable    = enable_q;
  assign bus.lo_ind    = '0;
  assign bus.hi_ind    = hi_q;
  assign bus.res_array = res_array_q;
  assign bus.res_count = res_count_q;
  assign bus.res_valid = (state == DONE);

endmodule

// File: tb/tb_quicksort_loader.sv
// tb_quicksort_loader: directed and random frames through the loader with a sorter stub.
// Latency: n/a.
// Backpressure: res_ready driven fixed or random; stub delays array_valid rise and fall.
module tb_quicksort_loader;

  typedef struct {
    logic [15:0] padded;
    logic [15:0] res;
    int          n;
    logic        err;
  } frame_t;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 0;
  int   rr_mode  = 1;
  bit   stub_never = 0;
  bit   stale_mode = 0;
  bit   tmo_mode   = 0;
  frame_t q[$];

  quicksort_loader_if #(.ARR_WIDTH(4), .ELEM_W(4), .IDX_W(4)) bus ();

  quicksort_loader #(
    .ARR_WIDTH(4), .ELEM_W(4), .IDX_W(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pad(input logic [15:0] e, input int n);
    logic [15:0] r = 16'hFFFF;
    for (int k = 0; k < n; k++) r[15-4*k -: 4] = e[15-4*k -: 4];
    return r;
  endfunction

  // Ascending order, smallest element at the MSB end.
  function automatic logic [15:0] model_sort(input logic [15:0] w);
    logic [3:0]  e [4];
    logic [3:0]  tmp;
    logic [15:0] r;
    for (int i = 0; i < 4; i++) e[i] = w[15-4*i -: 4];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (e[j] > e[j+1]) begin tmp = e[j]; e[j] = e[j+1]; e[j+1] = tmp; end
    for (int i = 0; i < 4; i++) r[15-4*i -: 4] = e[i];
    return r;
  endfunction

  // Downstream consumer.
  initial begin
    bus.res_ready = 0;
    forever begin
      @(negedge clock);
      if (rr_mode == 0)      bus.res_ready = 0;
      else if (rr_mode == 1) bus.res_ready = 1;
      else                   bus.res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Sorter stub: random rise delay, holds while enable is high, random fall delay.
  initial begin
    int dly = 0;
    int fall = 0;
    bit seen = 0;
    bit stale_on = 0;
    bus.array_valid = 0;
    bus.sorted_array = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        bus.array_valid = 0; seen = 0; stale_on = 0;
      end else if (bus.enable && !stub_never) begin
        if (stale_on) begin
          bus.array_valid = 0; stale_on = 0;
        end else if (!seen && stale_mode) begin
          seen = 1; stale_on = 1; bus.array_valid = 1; bus.sorted_array = 16'hABCD;
        end else begin
          seen = 1;
          if (!bus.array_valid) begin
            if (dly == 0) begin
              bus.array_valid = 1; bus.sorted_array = model_sort(bus.array_in);
            end else dly--;
          end
        end
      end else if (!bus.enable) begin
        seen = 0;
        if (bus.array_valid) begin
          if (fall == 0) bus.array_valid = 0; else fall--;
        end else begin
          dly = $urandom_range(0, 4); fall = $urandom_range(0, 3);
        end
      end
    end
  end

  // Per-cycle comparison against the frame scoreboard.
  initial begin
    bit drain = 0;
    int run = 0;
    forever begin
      @(negedge clock);
      #1;
      if (!chk_en) begin drain = 0; run = 0; continue; end
      if (drain) begin
        chk("turnaround_in_ready", bus.in_ready, (run == 3));
        if (bus.in_ready) drain = 0;
        else if (!bus.array_valid) run++;
        else run = 0;
      end
      if (bus.res_valid) begin
        if (q.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          chk("res_array", bus.res_array, q[0].res);
          chk("res_count", bus.res_count, q[0].n);
          chk("sort_err", bus.sort_err, q[0].err);
          chk("in_ready_during_result", bus.in_ready, 0);
          if (bus.res_ready) begin void'(q.pop_front()); drain = 1; run = 0; end
        end
      end else begin
        chk("sort_err_idle", bus.sort_err, 0);
      end
      if (q.size() > 0 && q[0].n == 1) chk("single_no_enable", bus.enable, 0);
      if (bus.enable) begin
        if (q.size() == 0) chk("enable_unexpected", 1, 0);
        else begin
          chk("array_in", bus.array_in, q[0].padded);
          chk("hi_ind", bus.hi_ind, q[0].n - 1);
          chk("lo_ind", bus.lo_ind, 0);
        end
      end
    end
  end

  // Caller is at a negedge; returns at the negedge after the closing beat.
  task automatic send_frame(input int n, input logic [15:0] elems, input bit use_last, input int gap_max);
    frame_t f;
    int t;
    f.n = n; f.padded = pad(elems, n);
    f.res = tmo_mode ? f.padded : model_sort(f.padded);
    f.err = tmo_mode;
    q.push_back(f);
    for (int k = 0; k < n; k++) begin
      int g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) begin
        bus.in_valid = 0; bus.in_last = 1'($urandom_range(0, 1)); @(negedge clock);
      end
      bus.in_valid = 1; bus.in_data = elems[15-4*k -: 4]; bus.in_last = use_last && (k == n - 1);
      t = 0;
      while (!bus.in_ready && t < 300) begin @(negedge clock); t++; end
      if (t >= 300) chk("in_ready_wait", bus.in_ready, 1);
      @(negedge clock);
    end
    bus.in_valid = 0; bus.in_last = 0;
  endtask

  task automatic wait_res(input string name, input logic [15:0] exp_arr, input int exp_cnt);
    int t = 0;
    while (!bus.res_valid && t < 200) begin @(negedge clock); t++; end
    chk({name, "_res_valid"}, bus.res_valid, 1);
    chk({name, "_res_array"}, bus.res_array, exp_arr);
    chk({name, "_res_count"}, bus.res_count, exp_cnt);
  endtask

  initial begin
    int t;
    int n_en;
    reset = 0; bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_enable", bus.enable, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_sort_err", bus.sort_err, 0);
    chk("rst_array_in", bus.array_in, 16'hFFFF);
    chk("rst_res_array", bus.res_array, 0);
    chk("rst_res_count", bus.res_count, 0);
    chk("rst_hi_ind", bus.hi_ind, 0);
    chk("rst_lo_ind", bus.lo_ind, 0);
    reset = 1;
    @(negedge clock);
    chk_en = 1;

    send_frame(4, 16'h5170, 1, 0);
    chk("full_array_in", bus.array_in, 16'h5170);
    chk("full_enable_rise", bus.enable, 1);
    chk("full_hi_ind", bus.hi_ind, 3);
    chk("full_lo_ind", bus.lo_ind, 0);
    wait_res("full", 16'h0157, 4);
    chk("full_sort_err", bus.sort_err, 0);

    send_frame(2, 16'h6200, 1, 0);
    chk("short_array_in", bus.array_in, 16'h62FF);
    chk("short_hi_ind", bus.hi_ind, 1);
    wait_res("short", 16'h26FF, 2);

    send_frame(1, 16'h3000, 1, 0);
    chk("single_enable", bus.enable, 0);
    chk("single_res_valid_early", bus.res_valid, 0);
    @(negedge clock);
    chk("single_res_valid", bus.res_valid, 1);
    chk("single_res_array", bus.res_array, 16'h3FFF);
    chk("single_enable_late", bus.enable, 0);

    rr_mode = 0;
    send_frame(4, 16'h9A31, 0, 0);
    wait_res("bp", 16'h139A, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_res_valid_hold", bus.res_valid, 1);
      chk("bp_res_array_hold", bus.res_array, 16'h139A);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    rr_mode = 1;

    stale_mode = 1;
    send_frame(3, 16'hC4E0, 1, 0);
    wait_res("stale", 16'h4CEF, 3);
    stale_mode = 0;

    stub_never = 1;
    send_frame(3, 16'h8420, 1, 0);
    t = 0;
    while (!bus.enable && t < 50) begin @(negedge clock); t++; end
    chk("rs_enable_before", bus.enable, 1);
    repeat (3) @(negedge clock);
    chk_en = 0;
    reset = 0;
    #1;
    chk("rs_enable", bus.enable, 0);
    chk("rs_res_valid", bus.res_valid, 0);
    chk("rs_in_ready", bus.in_ready, 0);
    chk("rs_array_in", bus.array_in, 16'hFFFF);
    q.delete();
    stub_never = 0;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    chk_en = 1;
    send_frame(4, 16'h2211, 1, 0);
    wait_res("after_reset", 16'h1122, 4);

`ifdef QS_LOADER_TIMEOUT_EN
    stub_never = 1; tmo_mode = 1;
    send_frame(2, 16'h9300, 1, 0);
    n_en = 0;
    while (bus.enable && n_en < 100) begin n_en++; @(negedge clock); end
    chk("tmo_enable_cycles", n_en, 16);
    chk("tmo_res_valid", bus.res_valid, 1);
    chk("tmo_sort_err", bus.sort_err, 1);
    chk("tmo_res_array", bus.res_array, 16'h93FF);
    stub_never = 0; tmo_mode = 0;
`else
    n_en = 0;
`endif

    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      int n = $urandom_range(1, 4);
      logic [15:0] el = 16'($urandom);
      bit ul = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      send_frame(n, el, ul, 3);
    end
    rr_mode = 1;
    t = 0;
    while (q.size() != 0 && t < 500) begin @(negedge clock); t++; end
    chk("queue_drained", q.size(), 0);
    repeat (8) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
